pipe_ctrl_nway: RTL and testbench
=================================

// Module: pipe_ctrl_nway
// PURPOSE
// - Central hazard/stall/flush controller for an N-lane in-order superscalar pipeline (IF, ID, EX, MEM, WB).
// - Successor of the fixed dual-issue controller. Adds:
//   - lane count as a parameter;
//   - sticky WFI sleep and fence-drain state machine;
//   - registered redirect held until the fetch unit accepts it;
//   - saturating stall/flush performance counters.
// - Sits beside the pipeline registers; drives their stall/flush enables, the per-lane kill masks and the fetch redirect.
// PARAMETERS
// - LANES       2   issue lanes; lane 0 is oldest in program order.
// - ADDR_WIDTH  32  PC width.
// - CNT_WIDTH   32  perf counter width (saturating).
// PORTS
// - clk                   in   1             core clock
// - rst                   in   1             synchronous, active-high reset
// - icache_stall_req      in   1             fetch miss in progress
// - dcache_stall_req      in   1             MEM-stage miss in progress
// - hazard_stall_req      in   1             decode RAW/structural hazard
// - ex_stall_req          in   1             multicycle EX op busy
// - id_fence              in   LANES         FENCE in ID, per lane
// - id_wfi                in   LANES         WFI in ID, per lane
// - ex_ldst / mem_ldst    in   LANES each    load/store in EX / MEM, per lane
// - ex_branch             in   LANES         taken/mispredicted branch resolved in EX, per lane
// - ex_branch_pc          in   LANES*ADDR_WIDTH  per-lane target; lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
// - csr_excp              in   1             trap/interrupt taken
// - csr_excp_pc           in   ADDR_WIDTH    trap vector
// - csr_wakeup            in   1             pending interrupt; ends WFI
// - ctrl_stall            out  5             stage hold: bit0 IF … bit4 WB
// - flush                 out  4             boundary clear: bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB
// - id_lane_hold          out  LANES         ID lanes not allowed to issue this cycle
// - ex_lane_kill          out  LANES         EX lanes squashed (younger than the redirecting branch)
// - redirect_valid        out  1             fetch redirect request
// - redirect_pc           out  ADDR_WIDTH    redirect target
// - redirect_ready        in   1             fetch accepted redirect this cycle
// - ctrl_state            out  2             FSM state, for debug
// - stall_cycles          out  CNT_WIDTH     cycles with any ctrl_stall bit set
// - flush_events          out  CNT_WIDTH     redirects issued
// BEHAVIOUR
// - Reset: all outputs 0; state RUN; counters 0; pending redirect cleared. Reset mid-sleep or mid-drain returns to RUN next cycle.
// - FSM: RUN=0, FENCE_DRAIN=1, WFI_SLEEP=2, REDIRECT=3.
//   - RUN -> WFI_SLEEP: any id_wfi set, no csr_excp, no ex_branch.
//   - WFI_SLEEP: ctrl_stall=5'b11111. Leaves to RUN on csr_wakeup (stall drops the same cycle) or on csr_excp.
//   - RUN -> FENCE_DRAIN: any id_fence set and any ex_ldst/mem_ldst set or dcache_stall_req high.
//   - FENCE_DRAIN: ctrl_stall=5'b00011; id_lane_hold = fence lane and all younger lanes. Returns to RUN in the first cycle with no ldst in EX/MEM and no dcache stall.
//   - Any state -> REDIRECT: csr_excp or any ex_branch. redirect_valid=1; held, with redirect_pc stable, until redirect_ready. Then RUN. If redirect_ready is already high in the entry cycle, REDIRECT lasts 0 cycles.
// - Redirect source:
//   - csr_excp beats branches; csr_excp_pc is used.
//   - Otherwise the oldest (lowest-index) ex_branch lane k wins; ex_branch_pc of lane k is used.
//   - Entry cycle: flush=4'b0011; ex_lane_kill = lanes >k (0 for an exception).
//   - csr_excp additionally sets flush bit2.
//   - While in REDIRECT: flush bit0 stays 1. A csr_excp in REDIRECT overwrites redirect_pc; a new ex_branch is ignored (wrong-path).
// - Combinational stall priority in RUN (first match wins):
//   1. dcache_stall_req -> 5'b00111, flush bit2 (bubble into MEM/WB).
//   2. hazard_stall_req -> 5'b00011, flush bit1.
//   3. ex_stall_req -> 5'b00111, flush bit2.
//   4. icache_stall_req -> 5'b00001, flush bit0.
//   5. None -> 0.
// - Redirect flush bits are ORed with stall-derived flush bits. Redirect has priority over every stall except WFI_SLEEP exit rules.
// - Counters:
//   - stall_cycles +1 when ctrl_stall!=0.
//   - flush_events +1 on each REDIRECT entry.
//   - Both saturate at all-ones, no wrap.
// STRUCTURE
// - Shared package/defines: state encodings, stall and flush bit positions, ADDR_WIDTH.
// - One sub-module: pipe_ctrl_prio_pick (oldest-set-bit priority encoder plus younger-lane mask), reused for the branch lane and the fence lane.
// TESTING
// 1. LANES=2, ex_branch=2'b11, pc0=0x100, pc1=0x200, redirect_ready=1:
//    -> redirect_pc=0x100, flush=4'b0011, ex_lane_kill=2'b10, flush_events=1.
// 2. ex_branch[1] with redirect_ready low for 3 cycles:
//    -> redirect_valid held 4 cycles, pc stable.
//    -> csr_excp in cycle 2 switches redirect_pc to csr_excp_pc.
// 3. id_fence[0] with mem_ldst=2'b01 for 2 cycles:
//    -> FENCE_DRAIN 2 cycles, ctrl_stall=5'b00011, id_lane_hold=2'b11, then RUN.
// 4. id_wfi[1]:
//    -> ctrl_stall=5'b11111 until csr_wakeup. 10 sleep cycles give stall_cycles=10.
//    -> rst mid-sleep gives RUN and all outputs 0 next cycle.
// 5. dcache_stall_req with hazard_stall_req and icache_stall_req together:
//    -> ctrl_stall=5'b00111, flush=4'b0100.
// 6. CNT_WIDTH=4, 20 stall cycles -> stall_cycles=4'hF, no wrap.

Source files
------------

// File: rtl/pipe_ctrl_nway_pkg.sv
// pipe_ctrl_nway_pkg: shared encodings for the
// N-lane hazard/stall/flush controller.
package pipe_ctrl_nway_pkg;

  localparam int DEF_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FENCE = 2'd1,
    ST_WFI   = 2'd2,
    ST_REDIR = 2'd3
  } ctrl_state_t;

  localparam int FL_IF_ID  = 0;
  localparam int FL_ID_EX  = 1;
  localparam int FL_EX_MEM = 2;

  localparam logic [4:0] STALL_IF    = 5'b00001;
  localparam logic [4:0] STALL_IF_ID = 5'b00011;
  localparam logic [4:0] STALL_IF_EX = 5'b00111;
  localparam logic [4:0] STALL_ALL   = 5'b11111;

endpackage

// File: rtl/pipe_ctrl_prio_pick.sv
// pipe_ctrl_prio_pick: oldest-set-bit picker
// with a mask of all lanes younger than it.
module pipe_ctrl_prio_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [N-1:0] first,
  output logic [N-1:0] younger
);

  logic found;

  // walk from lane 0 (oldest); lanes after the hit are younger
  always_comb begin
    found   = 1'b0;
    first   = '0;
    younger = '0;
    for (int i = 0; i < N; i++) begin
      if (found) begin
        younger[i] = 1'b1;
      end else if (req[i]) begin
        first[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/pipe_ctrl_nway.sv
// pipe_ctrl_nway: hazard/stall/flush controller
// for an N-lane in-order pipeline.
module pipe_ctrl_nway
  import pipe_ctrl_nway_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        icache_stall_req,
  input  logic                        dcache_stall_req,
  input  logic                        hazard_stall_req,
  input  logic                        ex_stall_req,
  input  logic [LANES-1:0]            id_fence,
  input  logic [LANES-1:0]            id_wfi,
  input  logic [LANES-1:0]            ex_ldst,
  input  logic [LANES-1:0]            mem_ldst,
  input  logic [LANES-1:0]            ex_branch,
  input  logic [LANES*ADDR_WIDTH-1:0] ex_branch_pc,
  input  logic                        csr_excp,
  input  logic [ADDR_WIDTH-1:0]       csr_excp_pc,
  input  logic                        csr_wakeup,
  output logic [4:0]                  ctrl_stall,
  output logic [3:0]                  flush,
  output logic [LANES-1:0]            id_lane_hold,
  output logic [LANES-1:0]            ex_lane_kill,
  output logic                        redirect_valid,
  output logic [ADDR_WIDTH-1:0]       redirect_pc,
  input  logic                        redirect_ready,
  output logic [1:0]                  ctrl_state,
  output logic [CNT_WIDTH-1:0]        stall_cycles,
  output logic [CNT_WIDTH-1:0]        flush_events
);

  ctrl_state_t           state, state_nx;
  logic [ADDR_WIDTH-1:0] rpc_q, rpc_nx, br_pc;
  logic [LANES-1:0]      hold_q, hold_nx;
  logic [LANES-1:0]      br_first, br_young;
  logic [LANES-1:0]      fn_first, fn_young;
  logic                  br_any, fn_any;
  logic                  ldst_busy, take, entry;
  logic [4:0]            st_stall;
  logic [3:0]            st_flush;

  pipe_ctrl_prio_pick #(.N(LANES)) u_br_pick (
    .req     (ex_branch),
    .any     (br_any),
    .first   (br_first),
    .younger (br_young)
  );

  pipe_ctrl_prio_pick #(.N(LANES)) u_fn_pick (
    .req     (id_fence),
    .any     (fn_any),
    .first   (fn_first),
    .younger (fn_young)
  );

  assign ldst_busy = (|ex_ldst) | (|mem_ldst)
                   | dcache_stall_req;

  // branches are wrong-path while asleep or redirecting
  assign take  = csr_excp
               | (br_any & ((state == ST_RUN)
                          | (state == ST_FENCE)));
  assign entry = take & (state != ST_REDIR);

  assign ctrl_state = rst ? 2'b00 : state;

  // target of the oldest taken branch lane
  always_comb begin
    br_pc = '0;
    for (int i = 0; i < LANES; i++) begin
      if (br_first[i]) begin
        br_pc = ex_branch_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // stall request priority, first match wins
  always_comb begin
    st_stall = '0;
    st_flush = '0;
    if (dcache_stall_req) begin
      st_stall = STALL_IF_EX;
      st_flush[FL_EX_MEM] = 1'b1;
    end else if (hazard_stall_req) begin
      st_stall = STALL_IF_ID;
      st_flush[FL_ID_EX] = 1'b1;
    end else if (ex_stall_req) begin
      st_stall = STALL_IF_EX;
      st_flush[FL_EX_MEM] = 1'b1;
    end else if (icache_stall_req) begin
      st_stall = STALL_IF;
      st_flush[FL_IF_ID] = 1'b1;
    end
  end

  // next state and control outputs
  always_comb begin
    state_nx       = state;
    rpc_nx         = rpc_q;
    hold_nx        = hold_q;
    ctrl_stall     = st_stall;
    flush          = st_flush;
    id_lane_hold   = '0;
    ex_lane_kill   = '0;
    redirect_valid = 1'b0;
    redirect_pc    = rpc_q;
    unique case (state)
      ST_RUN: begin
        if (|id_wfi) begin
          state_nx = ST_WFI;
        end else if (fn_any && ldst_busy) begin
          state_nx = ST_FENCE;
          hold_nx  = fn_first | fn_young;
        end
      end
      ST_FENCE: begin
        ctrl_stall   = st_stall | STALL_IF_ID;
        id_lane_hold = hold_q;
        if (!ldst_busy) state_nx = ST_RUN;
      end
      ST_WFI: begin
        if (csr_wakeup || csr_excp) begin
          state_nx = ST_RUN;
        end else begin
          ctrl_stall = STALL_ALL;
          flush      = '0;
        end
      end
      ST_REDIR: begin
        redirect_valid   = 1'b1;
        flush[FL_IF_ID]  = 1'b1;
        if (redirect_ready) state_nx = ST_RUN;
      end
      default: state_nx = ST_RUN;
    endcase
    if (take) begin
      redirect_valid   = 1'b1;
      flush[FL_IF_ID]  = 1'b1;
      flush[FL_ID_EX]  = 1'b1;
      id_lane_hold     = '0;
      if (csr_excp) begin
        flush[FL_EX_MEM] = 1'b1;
        rpc_nx           = csr_excp_pc;
      end else begin
        rpc_nx       = br_pc;
        ex_lane_kill = br_young;
      end
      redirect_pc = rpc_nx;
      state_nx    = redirect_ready ? ST_RUN : ST_REDIR;
    end
    if (rst) begin
      ctrl_stall     = '0;
      flush          = '0;
      id_lane_hold   = '0;
      ex_lane_kill   = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

  // FSM state, held redirect target, fence hold mask
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      rpc_q  <= '0;
      hold_q <= '0;
    end else begin
      state  <= state_nx;
      rpc_q  <= rpc_nx;
      hold_q <= hold_nx;
    end
  end

  // saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if ((|ctrl_stall) && !(&stall_cycles))
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      if (entry && !(&flush_events))
        flush_events <= flush_events + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_nway.sv
// tb_pipe_ctrl_nway: scoreboard bench for the
// N-lane pipeline controller.
module tb_pipe_ctrl_nway;

  localparam int L  = 2;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_stall_req, dcache_stall_req;
  logic          hazard_stall_req, ex_stall_req;
  logic [L-1:0]  id_fence, id_wfi, ex_ldst, mem_ldst;
  logic [L-1:0]  ex_branch;
  logic [L*AW-1:0] ex_branch_pc;
  logic          csr_excp, csr_wakeup, redirect_ready;
  logic [AW-1:0] csr_excp_pc;

  logic [4:0]    ctrl_stall, ctrl_stall4;
  logic [3:0]    flush, flush4;
  logic [L-1:0]  id_lane_hold, id_lane_hold4;
  logic [L-1:0]  ex_lane_kill, ex_lane_kill4;
  logic          redirect_valid, redirect_valid4;
  logic [AW-1:0] redirect_pc, redirect_pc4;
  logic [1:0]    ctrl_state, ctrl_state4;
  logic [31:0]   stall_cycles, flush_events;
  logic [3:0]    stall_cycles4, flush_events4;

  always #5 clk = ~clk;

  pipe_ctrl_nway #(.LANES(L), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .icache_stall_req(icache_stall_req),
    .dcache_stall_req(dcache_stall_req),
    .hazard_stall_req(hazard_stall_req),
    .ex_stall_req(ex_stall_req),
    .id_fence(id_fence), .id_wfi(id_wfi),
    .ex_ldst(ex_ldst), .mem_ldst(mem_ldst),
    .ex_branch(ex_branch), .ex_branch_pc(ex_branch_pc),
    .csr_excp(csr_excp), .csr_excp_pc(csr_excp_pc),
    .csr_wakeup(csr_wakeup),
    .ctrl_stall(ctrl_stall), .flush(flush),
    .id_lane_hold(id_lane_hold),
    .ex_lane_kill(ex_lane_kill),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  pipe_ctrl_nway #(.LANES(L), .ADDR_WIDTH(AW),
                   .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .icache_stall_req(icache_stall_req),
    .dcache_stall_req(dcache_stall_req),
    .hazard_stall_req(hazard_stall_req),
    .ex_stall_req(ex_stall_req),
    .id_fence(id_fence), .id_wfi(id_wfi),
    .ex_ldst(ex_ldst), .mem_ldst(mem_ldst),
    .ex_branch(ex_branch), .ex_branch_pc(ex_branch_pc),
    .csr_excp(csr_excp), .csr_excp_pc(csr_excp_pc),
    .csr_wakeup(csr_wakeup),
    .ctrl_stall(ctrl_stall4), .flush(flush4),
    .id_lane_hold(id_lane_hold4),
    .ex_lane_kill(ex_lane_kill4),
    .redirect_valid(redirect_valid4),
    .redirect_pc(redirect_pc4),
    .redirect_ready(redirect_ready),
    .ctrl_state(ctrl_state4),
    .stall_cycles(stall_cycles4),
    .flush_events(flush_events4)
  );

  typedef struct {
    string       tag;
    logic [4:0]  stall;
    logic [3:0]  fl;
    logic [1:0]  hold;
    logic [1:0]  kill;
    logic        rv;
    logic [31:0] pc;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fe;
    logic [3:0]  sc4;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_chk = 0;
  int          n_err = 0;
  int unsigned m_sc = 0, m_fe = 0, m_sc4 = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".stall"}, 64'(ctrl_stall), 64'(e.stall));
      chk({e.tag, ".flush"}, 64'(flush), 64'(e.fl));
      chk({e.tag, ".hold"}, 64'(id_lane_hold), 64'(e.hold));
      chk({e.tag, ".kill"}, 64'(ex_lane_kill), 64'(e.kill));
      chk({e.tag, ".rv"}, 64'(redirect_valid), 64'(e.rv));
      if (e.rv)
        chk({e.tag, ".pc"}, 64'(redirect_pc), 64'(e.pc));
      chk({e.tag, ".state"}, 64'(ctrl_state), 64'(e.st));
      chk({e.tag, ".scnt"}, 64'(stall_cycles), 64'(e.sc));
      chk({e.tag, ".fcnt"}, 64'(flush_events), 64'(e.fe));
      chk({e.tag, ".scnt4"}, 64'(stall_cycles4),
          64'(e.sc4));
    end
  end

  task automatic idle();
    icache_stall_req = 0; dcache_stall_req = 0;
    hazard_stall_req = 0; ex_stall_req = 0;
    id_fence = 0; id_wfi = 0; ex_ldst = 0; mem_ldst = 0;
    ex_branch = 0; ex_branch_pc = 0;
    csr_excp = 0; csr_excp_pc = 0; csr_wakeup = 0;
    redirect_ready = 0;
  endtask

  // push this cycle's expectation, then advance one clock
  task automatic cyc(input string tag,
                     input logic [4:0] s, input logic [3:0] f,
                     input logic [1:0] h, input logic [1:0] k,
                     input logic v, input logic [31:0] pc,
                     input logic [1:0] st, input logic ev);
    exp_t x;
    x.tag = tag; x.stall = s; x.fl = f; x.hold = h;
    x.kill = k; x.rv = v; x.pc = pc; x.st = st;
    x.sc = m_sc; x.fe = m_fe; x.sc4 = 4'(m_sc4);
    q.push_back(x);
    if (rst) begin
      m_sc = 0; m_fe = 0; m_sc4 = 0;
    end else begin
      if (s != 0) begin
        m_sc++;
        if (m_sc4 < 15) m_sc4++;
      end
      if (ev) m_fe++;
    end
    @(posedge clk); #1;
  endtask

  task automatic nop(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    nop("reset");
    rst = 0;
    nop("idle");

    // sleep 10 cycles, wake
    id_wfi = 2'b10;
    nop("wfi_in");
    for (int i = 0; i < 10; i++)
      cyc("sleep", 5'b11111, 0, 0, 0, 0, 0, 2, 0);
    csr_wakeup = 1;
    cyc("wake", 0, 0, 0, 0, 0, 0, 2, 0);
    idle();
    nop("wake_run");

    // two branches, lane 0 wins, accepted at once
    ex_branch = 2'b11;
    ex_branch_pc = {32'h200, 32'h100};
    redirect_ready = 1;
    cyc("br2", 0, 4'b0011, 0, 2'b10, 1, 32'h100, 0, 1);
    idle();
    nop("br2_after");

    // lane 1 branch held, excp overwrites target
    ex_branch = 2'b10;
    ex_branch_pc = {32'h300, 32'h0};
    cyc("hold0", 0, 4'b0011, 0, 0, 1, 32'h300, 0, 1);
    ex_branch = 2'b01;
    ex_branch_pc = {32'h0, 32'h444};
    cyc("hold1", 0, 4'b0001, 0, 0, 1, 32'h300, 3, 0);
    ex_branch = 0;
    csr_excp = 1; csr_excp_pc = 32'h80;
    cyc("hold2", 0, 4'b0111, 0, 0, 1, 32'h80, 3, 0);
    csr_excp = 0; redirect_ready = 1;
    cyc("hold3", 0, 4'b0001, 0, 0, 1, 32'h80, 3, 0);
    idle();
    nop("hold_done");

    // fence on lane 0 behind a MEM load
    id_fence = 2'b01; mem_ldst = 2'b01;
    nop("fence_in");
    cyc("drain1", 5'b00011, 0, 2'b11, 0, 0, 0, 1, 0);
    mem_ldst = 0;
    cyc("drain2", 5'b00011, 0, 2'b11, 0, 0, 0, 1, 0);
    idle();
    nop("fence_out");

    // fence on lane 1 behind an EX store
    id_fence = 2'b10; ex_ldst = 2'b01;
    nop("fence1_in");
    ex_ldst = 0;
    cyc("drain_l1", 5'b00011, 0, 2'b10, 0, 0, 0, 1, 0);
    idle();
    nop("fence1_out");

    // trap wakes the core out of sleep
    id_wfi = 2'b01;
    nop("wfi2_in");
    cyc("sleep2", 5'b11111, 0, 0, 0, 0, 0, 2, 0);
    cyc("sleep2", 5'b11111, 0, 0, 0, 0, 0, 2, 0);
    id_wfi = 0; csr_excp = 1; csr_excp_pc = 32'hA0;
    cyc("wfi_excp", 0, 4'b0111, 0, 0, 1, 32'hA0, 2, 1);
    csr_excp = 0; redirect_ready = 1;
    cyc("wfi_redir", 0, 4'b0001, 0, 0, 1, 32'hA0, 3, 0);
    idle();
    nop("wfi_excp_out");

    // reset in the middle of sleep
    id_wfi = 2'b01;
    nop("wfi3_in");
    for (int i = 0; i < 3; i++)
      cyc("sleep3", 5'b11111, 0, 0, 0, 0, 0, 2, 0);
    rst = 1;
    nop("rst_sleep");
    rst = 0;
    idle();
    nop("rst_after");

    // stall priority
    dcache_stall_req = 1; hazard_stall_req = 1;
    icache_stall_req = 1;
    cyc("prio_dc", 5'b00111, 4'b0100, 0, 0, 0, 0, 0, 0);
    dcache_stall_req = 0;
    cyc("prio_hz", 5'b00011, 4'b0010, 0, 0, 0, 0, 0, 0);
    hazard_stall_req = 0; ex_stall_req = 1;
    cyc("prio_ex", 5'b00111, 4'b0100, 0, 0, 0, 0, 0, 0);
    ex_stall_req = 0;
    cyc("prio_ic", 5'b00001, 4'b0001, 0, 0, 0, 0, 0, 0);
    idle();
    dcache_stall_req = 1; ex_branch = 2'b01;
    ex_branch_pc = {32'h2000, 32'h1000};
    redirect_ready = 1;
    cyc("br_dc", 5'b00111, 4'b0111, 0, 2'b10, 1,
        32'h1000, 0, 1);
    idle();
    csr_excp = 1; csr_excp_pc = 32'hC0;
    ex_branch = 2'b01; redirect_ready = 1;
    cyc("excp", 0, 4'b0111, 0, 0, 1, 32'hC0, 0, 1);
    idle();
    nop("idle2");

    // 4-bit counter saturates
    icache_stall_req = 1;
    for (int i = 0; i < 20; i++)
      cyc("sat", 5'b00001, 4'b0001, 0, 0, 0, 0, 0, 0);
    idle();
    nop("sat_end");
    chk("sat4_final", 64'(stall_cycles4), 64'hF);

    @(negedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
